// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and line levels for serial_tx
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/bit_tick_counter.sv
// rtl/bit_tick_counter.sv - per-bit cycle counter; tick marks the last cycle of a line bit
module bit_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] count;

  assign tick = !clear && (count == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-in serial-out frame transmitter
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_line,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic                  line_next;
  logic                  done_next;
  logic                  tick;
  logic                  accept;
  logic                  last_data;
  logic                  last_stop;

  assign tx_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

  bit_tick_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^tx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx_line <= LINE_IDLE;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      tx_line <= line_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept) state_next = START;
      START:  if (tick) state_next = DATA;
      DATA: begin
        if (tick && last_data) begin
`ifdef SERIAL_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (tick) state_next = STOP;
`endif
      STOP:   if (tick && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx_line is registered, so it is derived from the values the registers are about to take
  always_comb begin
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
    if (accept) begin
      shreg_next   = tx_data;
      bit_cnt_next = '0;
    end else if (tick && state == DATA) begin
      shreg_next   = shreg >> 1;
      bit_cnt_next = last_data ? '0 : bit_cnt + BW'(1);
    end else if (tick && state == STOP) begin
      bit_cnt_next = last_stop ? '0 : bit_cnt + BW'(1);
      done_next    = last_stop;
    end

    case (state_next)
      START:   line_next = LINE_START;
      DATA:    line_next = shreg_next[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  line_next = parity_q;
`endif
      default: line_next = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed self-checking bench for serial_tx
`timescale 1ns/1ps
module tb_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME0 = (1 + DW + P + 1) * CPB;
  localparam int FRAME1 = (1 + DW + P + 2);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data0, data1;
  logic          valid0, valid1;
  logic          ready0, ready1;
  logic          line0, line1;
  logic          busy0, busy1;
  logic          done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx_data(data0), .tx_valid(valid0),
    .tx_ready(ready0), .tx_line(line0), .busy(busy0), .done(done0)
  );

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .tx_line(line1), .busy(busy1), .done(done1)
  );

  // expected line level k cycles after accept
  function automatic logic exp_bit(input logic [7:0] w, input int k, input int cpb);
    int slot;
    slot = k / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return w[slot-1];
    if (P == 1 && slot == 9) return ^w;
    return 1'b1;
  endfunction

  task automatic start0(input logic [7:0] w);
    @(negedge clk);
    valid0 = 1'b1;
    data0  = w;
    @(posedge clk); #1;
    valid0 = 1'b0;
    data0  = ~w;
  endtask

  // called just after the accept edge; returns just after the done edge
  task automatic check_frame0(input logic [7:0] w, input int inject_at, input string tag);
    for (int k = 0; k < FRAME0; k++) begin
      if (k == inject_at) begin
        valid0 = 1'b1;
        data0  = 8'hFF;
      end else if (k == inject_at + 1) begin
        valid0 = 1'b0;
      end
      n_cmp++;
      if (line0 !== exp_bit(w, k, CPB)) begin
        n_bad++;
        $display("FAIL %s line cyc %0d: got %b want %b", tag, k, line0, exp_bit(w, k, CPB));
      end
      n_cmp++;
      if ({ready0, busy0, done0} !== 3'b010) begin
        n_bad++;
        $display("FAIL %s flags cyc %0d: ready/busy/done got %b want 010", tag, k, {ready0, busy0, done0});
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({done0, ready0, busy0, line0} !== 4'b1101) begin
      n_bad++;
      $display("FAIL %s end: done/ready/busy/line got %b want 1101", tag, {done0, ready0, busy0, line0});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    data0 = '0; data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({line0, ready0, busy0, done0} !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset0: line/ready/busy/done got %b want 1100", {line0, ready0, busy0, done0});
    end
    n_cmp++;
    if ({line1, ready1, busy1, done1} !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset1: line/ready/busy/done got %b want 1100", {line1, ready1, busy1, done1});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    start0(8'hA5);
    check_frame0(8'hA5, -100, "a5");
    @(posedge clk); #1;
    n_cmp++;
    if ({done0, ready0, line0} !== 3'b011) begin
      n_bad++;
      $display("FAIL a5 post: done/ready/line got %b want 011", {done0, ready0, line0});
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       par   [2];
    words[0] = 8'hA5; par[0] = 1'b0;
    words[1] = 8'h07; par[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start0(words[i]);
      repeat (9 * CPB + 1) @(posedge clk);
      #1;
      n_cmp++;
      if (line0 !== par[i]) begin
        n_bad++;
        $display("FAIL parity %h: got %b want %b", words[i], line0, par[i]);
      end
      repeat (44 - (9 * CPB + 1)) @(posedge clk);
      #1;
      n_cmp++;
      if ({done0, ready0} !== 2'b11) begin
        n_bad++;
        $display("FAIL parity len %h: done/ready got %b want 11", words[i], {done0, ready0});
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_back_to_back();
    @(negedge clk);
    valid0 = 1'b1;
    data0  = 8'h00;
    @(posedge clk); #1;
    check_frame0(8'h00, -100, "b2b0");
    data0 = 8'hFF;
    @(posedge clk); #1;
    valid0 = 1'b0;
    data0  = 8'h5A;
    check_frame0(8'hFF, -100, "b2b1");
    @(posedge clk); #1;
    n_cmp++;
    if ({done0, ready0} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b post: done/ready got %b want 01", {done0, ready0});
    end
  endtask

  task automatic test_reset_mid();
    start0(8'h3C);
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({line0, busy0, ready0, done0} !== 4'b1010) begin
      n_bad++;
      $display("FAIL midreset: line/busy/ready/done got %b want 1010", {line0, busy0, ready0, done0});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done0 !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset done cyc %0d: got %b want 0", i, done0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    start0(8'h81);
    check_frame0(8'h81, -100, "81");
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy();
    start0(8'h55);
    check_frame0(8'h55, 10, "ign");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({done0, ready0, line0} !== 3'b011) begin
        n_bad++;
        $display("FAIL ign post %0d: done/ready/line got %b want 011", i, {done0, ready0, line0});
      end
    end
  endtask

  task automatic test_fast_two_stop();
    @(negedge clk);
    valid1 = 1'b1;
    data1  = 8'h01;
    @(posedge clk); #1;
    valid1 = 1'b0;
    data1  = 8'hFE;
    for (int k = 0; k < FRAME1; k++) begin
      n_cmp++;
      if ({line1, done1} !== {exp_bit(8'h01, k, 1), 1'b0}) begin
        n_bad++;
        $display("FAIL fast cyc %0d: line/done got %b want %b0", k, {line1, done1}, exp_bit(8'h01, k, 1));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({done1, ready1, line1} !== 3'b111) begin
      n_bad++;
      $display("FAIL fast end: done/ready/line got %b want 111", {done1, ready1, line1});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid();
    test_ignore_busy();
    test_fast_two_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
